// File: rtl/draw_playfield.sv
// Tetris playfield renderer: frame border, checker/grid field, border flash.
// Two-stage pixel pipeline with a vsync-paced flash FSM.
module draw_playfield #(
  parameter int          HOR_PIX       = 1024,
  parameter int          VER_PIX       = 768,
  parameter int          GRID_SIZE     = 16,
  parameter int          FRAME_X_SIZE  = 40,
  parameter int          FRAME_Y_SIZE  = 20,
  parameter int          FRAME_WIDTH   = 1,
  parameter logic [11:0] BORDER_COLOR  = 12'h740,
  parameter logic [11:0] FLASH_COLOR   = 12'hF00,
  parameter logic [11:0] BG_COLOR      = 12'hDA5,
  parameter logic [11:0] BG_ALT_COLOR  = 12'hC94,
  parameter logic [11:0] LINE_COLOR    = 12'hA73,
  parameter int          FLASH_TOGGLES = 6
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [1:0]  mode_in,
  input  logic        flash_req,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        in_field_out,
  output logic [6:0]  grid_x_out,
  output logic [5:0]  grid_y_out,
  output logic        flash_busy
);

  localparam int LOG2 = $clog2(GRID_SIZE);
  localparam int XO_I = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2;
  localparam int YO_I = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2;
  localparam int XI_I = XO_I + FRAME_WIDTH * GRID_SIZE;
  localparam int YI_I = YO_I + FRAME_WIDTH * GRID_SIZE;

  localparam logic [10:0] XO  = 11'(XO_I);
  localparam logic [10:0] YO  = 11'(YO_I);
  localparam logic [10:0] XI  = 11'(XI_I);
  localparam logic [10:0] YI  = 11'(YI_I);
  localparam logic [10:0] XOR = 11'(HOR_PIX - XO_I);
  localparam logic [10:0] YOR = 11'(VER_PIX - YO_I);
  localparam logic [10:0] XIR = 11'(HOR_PIX - XI_I);
  localparam logic [10:0] YIR = 11'(VER_PIX - YI_I);

  typedef enum logic [1:0] {IDLE, ON, OFF} flash_e;

  flash_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q;
  logic        vs_q;
  logic        vs_rise;
  logic        flash_on;

  logic        blank;
  logic        outer;
  logic        inner;
  logic [10:0] dx;
  logic [10:0] dy;

  logic [25:0] tim1_q;
  logic        blank1_q;
  logic        border1_q;
  logic        field1_q;
  logic        line1_q;
  logic [6:0]  gx1_q;
  logic [5:0]  gy1_q;
  logic [11:0] rgb_d;

  assign vs_rise = vsync_in & ~vs_q;

  // Stage 1: classify the pixel against the frame geometry
  assign blank = hblnk_in | vblnk_in;
  assign outer = (hcount_in >= XO) && (hcount_in < XOR) &&
                 (vcount_in >= YO) && (vcount_in < YOR);
  assign inner = (hcount_in >= XI) && (hcount_in < XIR) &&
                 (vcount_in >= YI) && (vcount_in < YIR);
  assign dx = hcount_in - XI;
  assign dy = vcount_in - YI;

  always_ff @(posedge pclk) begin
    if (rst) begin
      tim1_q    <= '0;
      blank1_q  <= 1'b0;
      border1_q <= 1'b0;
      field1_q  <= 1'b0;
      line1_q   <= 1'b0;
      gx1_q     <= '0;
      gy1_q     <= '0;
    end else begin
      tim1_q    <= {hcount_in, vcount_in, hsync_in,
                    hblnk_in, vsync_in, vblnk_in};
      blank1_q  <= blank;
      border1_q <= ~blank & outer & ~inner;
      field1_q  <= ~blank & inner;
      line1_q   <= ~blank & inner &
                   ((&dx[LOG2-1:0]) | (&dy[LOG2-1:0]));
      gx1_q     <= (~blank & inner) ? 7'(dx >> LOG2) : 7'd0;
      gy1_q     <= (~blank & inner) ? 6'(dy >> LOG2) : 6'd0;
    end
  end

  // Stage 2: colour selection
  always_comb begin
    rgb_d = BG_COLOR;
    unique case (1'b1)
      blank1_q:  rgb_d = 12'h000;
      border1_q: rgb_d = flash_on ? FLASH_COLOR : BORDER_COLOR;
      field1_q: begin
        if (mode_q == 2'd1 && (gx1_q[0] ^ gy1_q[0]))
          rgb_d = BG_ALT_COLOR;
        else if (mode_q == 2'd2 && line1_q)
          rgb_d = LINE_COLOR;
      end
      default:   rgb_d = BG_COLOR;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      {hcount_out, vcount_out, hsync_out,
       hblnk_out, vsync_out, vblnk_out} <= '0;
      rgb_out      <= '0;
      in_field_out <= 1'b0;
      grid_x_out   <= '0;
      grid_y_out   <= '0;
    end else begin
      {hcount_out, vcount_out, hsync_out,
       hblnk_out, vsync_out, vblnk_out} <= tim1_q;
      rgb_out      <= rgb_d;
      in_field_out <= field1_q;
      grid_x_out   <= gx1_q;
      grid_y_out   <= gy1_q;
    end
  end

  // Flash FSM and per-frame mode latch
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= vs_rise ? mode_in : mode_q;
      vs_q    <= vsync_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flash_req) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON, OFF: begin
        if (vs_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(FLASH_TOGGLES))
            state_d = IDLE;
          else
            state_d = (state_q == ON) ? OFF : ON;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flash_on   = (state_q == ON);
    flash_busy = (state_q != IDLE);
  end

endmodule

// File: doc/draw_playfield.md
DRAW_PLAYFIELD -- requirements
Module: draw_playfield

Interface
REQ-001 SHALL: reset is synchronous and active-high; one clock; ports named pclk and rst as elsewhere in the codebase.
REQ-002 SHALL param HOR_PIX, 1024, active horizontal pixels.
REQ-003 SHALL param VER_PIX, 768, active vertical pixels.
REQ-004 SHALL param GRID_SIZE, 16, cell size in px; power of two, 4..64.
REQ-005 SHALL param FRAME_X_SIZE, 40, outer frame width in cells, border included.
REQ-006 SHALL param FRAME_Y_SIZE, 20, outer frame height in cells, border included.
REQ-007 SHALL param FRAME_WIDTH, 1, border thickness in cells.
REQ-008 SHALL param BORDER_COLOR 12'h740, FLASH_COLOR 12'hF00, BG_COLOR 12'hDA5, BG_ALT_COLOR 12'hC94, LINE_COLOR 12'hA73.
REQ-009 SHALL param FLASH_TOGGLES, 6, ON/OFF phase changes per flash burst, 1..255.
REQ-010 SHALL port pclk in 1, pixel clock.
REQ-011 SHALL port rst in 1, sync reset.
REQ-012 SHALL port hcount_in/vcount_in in 11 each; hsync_in, hblnk_in, vsync_in, vblnk_in in 1 each; VGA timing.
REQ-013 SHALL port mode_in in 2: 0 plain, 1 checkerboard, 2 grid lines, 3 treated as 0.
REQ-014 SHALL port flash_req in 1, single-cycle request for a border flash burst.
REQ-015 SHALL port hcount_out/vcount_out out 11; hsync_out, hblnk_out, vsync_out, vblnk_out out 1; timing delayed.
REQ-016 SHALL port rgb_out out 12, pixel colour.
REQ-017 SHALL port in_field_out out 1, pixel lies inside the border.
REQ-018 SHALL port grid_x_out out 7, grid_y_out out 6, field cell index.
REQ-019 SHALL port flash_busy out 1, high while a flash burst runs.

Function
REQ-020 SHALL: X_OUT=(HOR_PIX-FRAME_X_SIZE*GRID_SIZE)/2, Y_OUT likewise; X_IN=X_OUT+FRAME_WIDTH*GRID_SIZE, Y_IN likewise; defaults 192/224/208/240.
REQ-021 SHALL: latency exactly 2 pclk; all timing outputs, rgb_out, in_field_out and grid_*_out are mutually aligned.
REQ-022 SHALL: blanked pixel (hblnk_in|vblnk_in) -> rgb 12'h000, in_field 0, grid 0.
REQ-023 SHALL: border = inside outer rectangle [X_OUT, HOR_PIX-X_OUT) x [Y_OUT, VER_PIX-Y_OUT) and outside inner rectangle [X_IN, HOR_PIX-X_IN) x [Y_IN, VER_PIX-Y_IN).
REQ-024 SHALL: border colour is FLASH_COLOR while flash state is ON, else BORDER_COLOR.
REQ-025 SHALL: field pixel (inside inner rectangle) -> in_field 1; grid_x=(hcount-X_IN)>>log2(GRID_SIZE), grid_y likewise; non-field -> grid 0.
REQ-026 SHALL: field colour mode 0 -> BG_COLOR; mode 1 -> BG_ALT_COLOR when grid_x[0]^grid_y[0], else BG_COLOR; mode 2 -> LINE_COLOR when (hcount-X_IN) mod GRID_SIZE == GRID_SIZE-1 or (vcount-Y_IN) mod GRID_SIZE == GRID_SIZE-1, else BG_COLOR.
REQ-027 SHALL: all other active pixels -> BG_COLOR.
REQ-028 SHALL: mode_in sampled only on vsync_in rising edge (1-cycle delay detector); a mid-frame change takes effect next frame.
REQ-029 SHALL: flash FSM states IDLE, ON, OFF; IDLE+flash_req -> ON, toggle counter cleared.
REQ-030 SHALL: each vsync_in rising edge in ON/OFF increments counter and toggles ON<->OFF; on the edge where counter reaches FLASH_TOGGLES, go IDLE.
REQ-031 SHALL: flash_req while not IDLE is ignored; flash_req coincident with a vsync edge in IDLE -> ON, edge not counted.
REQ-032 SHALL: flash_busy = (state != IDLE), registered, no pipeline delay.

Reset
REQ-033 SHALL: on rst all outputs 0, flash FSM IDLE, counter 0, latched mode 0, vsync edge detector 0; reset mid-burst aborts it.

Verification
REQ-034 SHALL: defaults, mode 0, h=192 v=300 active -> after 2 cycles rgb 12'h740, in_field 0.
REQ-035 SHALL: h=208 v=240 -> rgb 12'hDA5, in_field 1, grid (0,0); h=815 v=527 -> grid (37,17); h=816 -> border.
REQ-036 SHALL: mode 1 latched, h=224 v=240 -> grid (1,0), rgb 12'hC94; mode 2, h=223 v=250 -> 12'hA73.
REQ-037 SHALL: mode_in 0->1 mid-frame -> field colours unchanged until next vsync_in rise.
REQ-038 SHALL: flash_req, 6 vsync rises -> border F00/740 alternating per frame, flash_busy high 6 frames then low; second flash_req during burst ignored.
REQ-039 SHALL: hblnk_in=1 at h=300 -> rgb 000; rst asserted mid-burst -> next cycle flash_busy 0, rgb_out 0.
